// File: rtl/data_mem_lsu.sv
// Byte-addressable 32-bit data memory with a load/store front end.
// Accepts one byte/half/word request per cycle, performs lane-masked stores,
// returns sign/zero-extended load data after 1 (OUT_REG=0) or 2 (OUT_REG=1)
// cycles, and flags misaligned or reserved-size requests.
module data_mem_lsu #(
   parameter int    DEPTH      = 1024,
   parameter int    ADDR_W     = $clog2(DEPTH) + 2,
   parameter int    OUT_REG    = 1,
   parameter string WRITE_MODE = "READ_FIRST",
   parameter string INIT_FILE  = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W    = ADDR_W - 2;
   localparam bit IS_WF    = (WRITE_MODE == "WRITE_FIRST");
   localparam bit IS_NC    = (WRITE_MODE == "NO_CHANGE");

   logic [31:0]      mem [DEPTH];

   logic [IDX_W-1:0] idx;
   logic [1:0]       off;
   logic             req_err;
   logic [3:0]       be;
   logic [31:0]      wdata_rep;
   logic [31:0]      old_word;
   logic [31:0]      merged_word;
   logic             do_write;

   logic             s1_valid;
   logic [31:0]      s1_word;
   logic [1:0]       s1_off;
   logic [1:0]       s1_size;
   logic             s1_signed;
   logic             s1_err;
   logic             s1_keep;

   logic [31:0]      shifted;
   logic [31:0]      ext_data;
   logic [31:0]      s1_rdata;
   logic [31:0]      hold_rdata;

   // Memory starts zeroed.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = '0;
      end
   end

   assign idx      = req_addr[ADDR_W-1:2];
   assign off      = req_addr[1:0];
   assign old_word = mem[idx];

   // Alignment / reserved-size check for the incoming request.
   always_comb begin
      req_err = 1'b0;
      case (req_size)
         2'b00:   req_err = 1'b0;
         2'b01:   req_err = off[0];
         2'b10:   req_err = (off != 2'b00);
         default: req_err = 1'b1;
      endcase
   end

   // Byte enables and lane-replicated store data.
   always_comb begin
      be        = 4'b0000;
      wdata_rep = req_wdata;
      case (req_size)
         2'b00: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be        = off[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            be        = 4'b1111;
            wdata_rep = req_wdata;
         end
         default: begin
            be        = 4'b0000;
            wdata_rep = req_wdata;
         end
      endcase
   end

   // Merge selected store lanes into the current word contents.
   always_comb begin
      merged_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged_word[8*i +: 8] = wdata_rep[8*i +: 8];
         end
      end
   end

   // Requests presented during reset or flagged as errors never write.
   assign do_write = req_valid & req_we & ~req_err & ~reset;

   // Memory write port; contents are not affected by reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[idx] <= merged_word;
      end
   end

   // Stage 1: capture the word and the request attributes needed for extraction.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_word   <= '0;
         s1_off    <= '0;
         s1_size   <= '0;
         s1_signed <= 1'b0;
         s1_err    <= 1'b0;
         s1_keep   <= 1'b0;
      end else begin
         s1_valid <= req_valid;
         if (req_valid) begin
            s1_word   <= (IS_WF && req_we) ? merged_word : old_word;
            s1_off    <= off;
            s1_size   <= req_size;
            s1_signed <= req_signed;
            s1_err    <= req_err;
            s1_keep   <= IS_NC && req_we && !req_err;
         end
      end
   end

   assign shifted = s1_word >> {s1_off, 3'b000};

   // Lane extraction with sign or zero extension.
   always_comb begin
      ext_data = s1_word;
      case (s1_size)
         2'b00:   ext_data = {{24{s1_signed & shifted[7]}}, shifted[7:0]};
         2'b01:   ext_data = {{16{s1_signed & shifted[15]}}, shifted[15:0]};
         default: ext_data = s1_word;
      endcase
   end

   // Response data: zero on error, previous response for NO_CHANGE stores.
   always_comb begin
      s1_rdata = ext_data;
      if (s1_err) begin
         s1_rdata = '0;
      end else if (s1_keep) begin
         s1_rdata = hold_rdata;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic        s2_valid;
         logic [31:0] s2_rdata;
         logic        s2_err;

         // Stage 2: output register; data/err hold while no response is issued.
         always_ff @(posedge clk) begin
            if (reset) begin
               s2_valid <= 1'b0;
               s2_rdata <= '0;
               s2_err   <= 1'b0;
            end else begin
               s2_valid <= s1_valid;
               if (s1_valid) begin
                  s2_rdata <= s1_rdata;
                  s2_err   <= s1_err;
               end
            end
         end

         assign hold_rdata = s2_rdata;
         assign rsp_valid  = s2_valid;
         assign rsp_rdata  = s2_rdata;
         assign rsp_err    = s2_err;
      end else begin : g_no_out_reg
         logic [31:0] last_rdata;

         // Remember the last delivered data so NO_CHANGE stores can repeat it.
         always_ff @(posedge clk) begin
            if (reset) begin
               last_rdata <= '0;
            end else if (s1_valid) begin
               last_rdata <= s1_rdata;
            end
         end

         assign hold_rdata = last_rdata;
         assign rsp_valid  = s1_valid;
         assign rsp_rdata  = s1_rdata;
         assign rsp_err    = s1_err;
      end
   endgenerate

endmodule
